ans_formatter: RTL and testbench
================================

ANS_FORMATTER -- requirements
Module: ans_formatter

Interface
- REQ-001 The block SHALL have parameter: CRLF, 1, when 1 append CR (0x0D), LF (0x0A) after the last digit; when 0 end after the last digit.
- REQ-002 The block SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
- REQ-003 The block SHALL have port: rst  input  1  asynchronous, active-high reset.
- REQ-004 The block SHALL have port: ans_ready  input  1  one-cycle strobe from op_controller; ans is valid this cycle.
- REQ-005 The block SHALL have port: ans  input  16  signed two's-complement answer from the stack top.
- REQ-006 The block SHALL have port: tx_data  output  8  ASCII byte offered to the UART transmitter.
- REQ-007 The block SHALL have port: tx_valid  output  1  tx_data is valid.
- REQ-008 The block SHALL have port: tx_ready  input  1  transmitter accepts the byte; a transfer occurs on a cycle with tx_valid && tx_ready.
- REQ-009 The block SHALL have port: busy  output  1  high in every state except IDLE.
- REQ-010 The block SHALL have port: drop  output  1  one-cycle pulse; an ans_ready was ignored.

Function
- REQ-011 The block SHALL be a registered FSM with states IDLE, SIGN, CALC, EMIT, CR, LF; all outputs SHALL be driven from registers or from state only.
- REQ-012 In IDLE on ans_ready the block SHALL latch:
  - neg = ans[15];
  - mag = |ans| as 17-bit unsigned, so -32768 gives 32768;
  - idx = 0 (power 10000), digit = 0, started = 0.
  - Next state SHALL be SIGN if neg, else CALC.
- REQ-013 SIGN SHALL present tx_data=0x2D with tx_valid=1; on transfer, next state SHALL be CALC.
- REQ-014 CALC SHALL perform at most one subtraction per cycle. Powers are 10000, 1000, 100, 10, 1 for idx 0..4.
  - If mag >= pow[idx]: mag -= pow[idx]; digit += 1.
  - Else, if digit!=0, started, or idx==4: set started=1; next state EMIT.
  - Else (leading zero, suppressed): idx += 1, digit = 0, remain in CALC.
- REQ-015 EMIT SHALL present tx_data=0x30+digit with tx_valid=1. On transfer:
  - If idx==4: next state CR when CRLF=1, else IDLE.
  - Otherwise: idx += 1, digit = 0, next state CALC.
- REQ-016 CR SHALL present 0x0D, then move to LF on transfer; LF SHALL present 0x0A, then move to IDLE on transfer.
- REQ-017 While tx_valid=1 and tx_ready=0, tx_data SHALL stay constant and tx_valid SHALL stay high, with no limit on stall length.
- REQ-018 tx_valid SHALL be 0 in IDLE and CALC.
- REQ-019 The first tx_valid SHALL rise on the cycle after ans_ready for negative ans. For non-negative ans it SHALL rise after the required CALC cycles; at most 9 subtractions per digit plus 1 decision cycle per idx.
- REQ-020 An ans_ready while busy=1 SHALL be ignored (no latch, no state change), and drop SHALL pulse high on the following cycle.
- REQ-021 ans_ready in the same cycle that LF (or the last EMIT when CRLF=0) transfers SHALL be dropped; it is accepted only from IDLE.
- REQ-022 The value 0 SHALL produce exactly "0"; no value SHALL produce leading zeros or "-0".

Reset
- REQ-023 While rst=1, asynchronously: state=IDLE, tx_valid=0, tx_data=0x00, busy=0, drop=0, mag=0, idx=0, digit=0, neg=0, started=0.
- REQ-024 Reset during any state, including mid-transfer stall, SHALL abort the answer; no further bytes of it SHALL be offered after rst deasserts.
- REQ-025 After rst deasserts, the first rising clk edge SHALL accept ans_ready.

Structure
- REQ-026 FSM state encodings, ASCII constants (0x2D, 0x30, 0x0D, 0x0A) and the power-of-ten constants SHALL live in the shared rpn_defs.vh include used by the RPN blocks.
- REQ-027 One sub-module SHALL be used: pow10_sel, combinational, mapping idx[2:0] to a 17-bit power of ten.
- REQ-028 Implementation size SHALL be 120-400 lines of RTL.

Verification
- REQ-029 ans=123, tx_ready=1 -> bytes 0x31,0x32,0x33,0x0D,0x0A in order, then busy=0.
- REQ-030 ans=0 -> 0x30,0x0D,0x0A; ans=-32768 -> 0x2D,0x33,0x32,0x37,0x36,0x38,0x0D,0x0A.
- REQ-031 ans=-7, tx_ready held 0 for 5 cycles during the 0x2D offer -> tx_data stays 0x2D with tx_valid=1; output is 0x2D,0x37,0x0D,0x0A.
- REQ-032 ans=42, second ans_ready with ans=99 while busy -> drop pulses once next cycle; output is "42" CRLF only.
- REQ-033 ans=12345, rst asserted mid-EMIT of 0x33 -> outputs at reset values immediately; after release, no byte until the next ans_ready.
- REQ-034 CRLF=0, ans=5 -> single byte 0x35, then IDLE.

Source files
------------

// File: rtl/ans_formatter_pkg.sv
// rtl/ans_formatter_pkg.sv - shared FSM states, ASCII and power-of-ten constants for ans_formatter
package ans_formatter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SIGN = 3'd1,
        ST_CALC = 3'd2,
        ST_EMIT = 3'd3,
        ST_CR   = 3'd4,
        ST_LF   = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam logic [16:0] POW10_4 = 17'd10000;
    localparam logic [16:0] POW10_3 = 17'd1000;
    localparam logic [16:0] POW10_2 = 17'd100;
    localparam logic [16:0] POW10_1 = 17'd10;
    localparam logic [16:0] POW10_0 = 17'd1;

    // idx of the units digit; it is always emitted, even when zero
    localparam logic [2:0] IDX_LAST = 3'd4;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASCII_ZERO + {4'd0, d};
    endfunction

endpackage

// File: rtl/ans_formatter_pow10_sel.sv
// rtl/ans_formatter_pow10_sel.sv - combinational idx to power-of-ten lookup
// Ports:
//   idx  : digit position, 0 = ten-thousands ... 4 = units
//   pow  : 17-bit power of ten for that position
module pow10_sel
    import ans_formatter_pkg::*;
(
    input  logic [2:0]  idx,
    output logic [16:0] pow
);

    always_comb begin
        pow = POW10_0;
        case (idx)
            3'd0:    pow = POW10_4;
            3'd1:    pow = POW10_3;
            3'd2:    pow = POW10_2;
            3'd3:    pow = POW10_1;
            default: pow = POW10_0;
        endcase
    end

endmodule

// File: rtl/ans_formatter.sv
// rtl/ans_formatter.sv - formats a signed 16-bit answer as ASCII decimal bytes for a UART
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   ans_ready  : one-cycle strobe, ans valid this cycle
//   ans        : signed 16-bit answer
//   tx_data    : ASCII byte offered to the transmitter
//   tx_valid   : tx_data valid; transfer on tx_valid && tx_ready
//   tx_ready   : transmitter accepts the byte
//   busy       : high in every state except IDLE
//   drop       : one-cycle pulse after an ignored ans_ready
module ans_formatter
    import ans_formatter_pkg::*;
#(
    parameter bit CRLF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ans_ready,
    input  logic [15:0] ans,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        drop
);

    state_t      r_state;
    logic [16:0] r_mag;
    logic [2:0]  r_idx;
    logic [3:0]  r_digit;
    logic        r_neg;
    logic        r_started;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_busy;
    logic        r_drop;

    logic [16:0] w_pow;
    logic [16:0] w_abs;
    logic        w_emit_now;

    pow10_sel u_pow10_sel (
        .idx (r_idx),
        .pow (w_pow)
    );

    // 17 bits so that -32768 negates to +32768 without overflow
    assign w_abs = ans[15] ? (17'd0 - {ans[15], ans}) : {1'b0, ans};

    // stop counting at this position and print it unless it is a leading zero
    assign w_emit_now = (r_digit != 4'd0) || r_started || (r_idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mag      <= 17'd0;
            r_idx      <= 3'd0;
            r_digit    <= 4'd0;
            r_neg      <= 1'b0;
            r_started  <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            // any strobe outside IDLE, including the final-transfer cycle, is lost
            r_drop <= ans_ready && (r_state != ST_IDLE);

            case (r_state)
                ST_IDLE: begin
                    if (ans_ready) begin
                        r_neg     <= ans[15];
                        r_mag     <= w_abs;
                        r_idx     <= 3'd0;
                        r_digit   <= 4'd0;
                        r_started <= 1'b0;
                        r_busy    <= 1'b1;
                        if (ans[15]) begin
                            r_state    <= ST_SIGN;
                            r_tx_data  <= ASCII_MINUS;
                            r_tx_valid <= 1'b1;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end

                ST_SIGN: begin
                    // SIGN is only entered with r_neg set; otherwise leave immediately
                    if (tx_ready || !r_neg) begin
                        r_state    <= ST_CALC;
                        r_tx_valid <= 1'b0;
                    end
                end

                ST_CALC: begin
                    if (r_mag >= w_pow) begin
                        r_mag   <= r_mag - w_pow;
                        r_digit <= r_digit + 4'd1;
                    end else if (w_emit_now) begin
                        r_started  <= 1'b1;
                        r_state    <= ST_EMIT;
                        r_tx_data  <= digit_ascii(r_digit);
                        r_tx_valid <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_digit <= 4'd0;
                    end
                end

                ST_EMIT: begin
                    if (tx_ready) begin
                        if (r_idx == IDX_LAST) begin
                            if (CRLF) begin
                                r_state   <= ST_CR;
                                r_tx_data <= ASCII_CR;
                            end else begin
                                r_state    <= ST_IDLE;
                                r_tx_valid <= 1'b0;
                                r_busy     <= 1'b0;
                            end
                        end else begin
                            r_idx      <= r_idx + 3'd1;
                            r_digit    <= 4'd0;
                            r_state    <= ST_CALC;
                            r_tx_valid <= 1'b0;
                        end
                    end
                end

                ST_CR: begin
                    if (tx_ready) begin
                        r_state   <= ST_LF;
                        r_tx_data <= ASCII_LF;
                    end
                end

                ST_LF: begin
                    if (tx_ready) begin
                        r_state    <= ST_IDLE;
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign drop     = r_drop;

endmodule

// File: tb/tb_ans_formatter.sv
// tb/tb_ans_formatter.sv - self-checking bench for ans_formatter against a decimal-string model
module tb_ans_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ans_ready1;
    logic        ans_ready0;
    logic [15:0] ans;
    logic        tx_ready;

    logic [7:0]  d1, d0;
    logic        v1, v0, b1, b0, dr1, dr0;

    int checks = 0;
    int errors = 0;

    bit          sel1;
    logic [7:0]  o_data;
    logic        o_valid, o_busy, o_drop;

    always #5 clk = ~clk;

    ans_formatter #(.CRLF(1'b1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .ans_ready (ans_ready1),
        .ans       (ans),
        .tx_data   (d1),
        .tx_valid  (v1),
        .tx_ready  (tx_ready),
        .busy      (b1),
        .drop      (dr1)
    );

    ans_formatter #(.CRLF(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .ans_ready (ans_ready0),
        .ans       (ans),
        .tx_data   (d0),
        .tx_valid  (v0),
        .tx_ready  (tx_ready),
        .busy      (b0),
        .drop      (dr0)
    );

    always_comb begin
        o_data  = sel1 ? d1  : d0;
        o_valid = sel1 ? v1  : v0;
        o_busy  = sel1 ? b1  : b0;
        o_drop  = sel1 ? dr1 : dr0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_strobe(input bit val);
        if (sel1) ans_ready1 = val;
        else      ans_ready0 = val;
    endtask

    // Sends one answer, collects every transferred byte until busy falls and
    // compares against the decimal rendering of v (plus CR LF on the CRLF=1 unit).
    task automatic run_ans(input string tag, input int v, input bit use1,
                           input int stall_first, input int drop_at);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        string      t;
        bit         pv, pr;
        logic [7:0] pd;
        int         cyc;
        logic [8:0] gb;

        sel1 = use1;
        t = $sformatf("%0d", v);
        for (int i = 0; i < t.len(); i++) exp_q.push_back(t[i]);
        if (use1) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end

        @(negedge clk);
        ans = v[15:0];
        set_strobe(1'b1);
        @(negedge clk);
        set_strobe(1'b0);
        if (v < 0) check({tag, " sign_latency"}, {23'd0, o_valid, o_data}, {23'd0, 1'b1, 8'h2D});

        pv = 1'b0; pr = 1'b0; pd = 8'h00; cyc = 0;
        while (o_busy && cyc < 400) begin
            if (pv && !pr) check({tag, " stall_hold"}, {23'd0, o_valid, o_data}, {23'd0, 1'b1, pd});
            if (cyc == drop_at) begin
                ans = 16'd99;
                set_strobe(1'b1);
            end
            if (drop_at >= 0 && cyc == drop_at + 1) begin
                set_strobe(1'b0);
                check({tag, " drop_pulse"}, {31'd0, o_drop}, 32'd1);
            end
            if (drop_at >= 0 && cyc == drop_at + 2)
                check({tag, " drop_once"}, {31'd0, o_drop}, 32'd0);
            tx_ready = (cyc < stall_first) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (o_valid && tx_ready) got_q.push_back(o_data);
            pv = o_valid; pr = tx_ready; pd = o_data;
            @(negedge clk);
            cyc++;
        end
        set_strobe(1'b0);
        tx_ready = 1'b1;

        check({tag, " finished"}, {31'd0, (cyc < 400)}, 32'd1);
        check({tag, " idle_valid"}, {31'd0, o_valid}, 32'd0);
        check({tag, " byte_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            gb = (i < got_q.size()) ? {1'b0, got_q[i]} : 9'h1FF;
            check($sformatf("%s byte%0d", tag, i), {23'd0, gb}, {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        int rv;
        int k;

        rst = 1'b1; ans_ready1 = 1'b0; ans_ready0 = 1'b0; ans = 16'd0; tx_ready = 1'b1; sel1 = 1'b1;
        #12;
        check("reset dut1", {20'd0, d1, v1, b1, dr1, 1'b0}, 32'd0);
        check("reset dut0", {20'd0, d0, v0, b0, dr0, 1'b0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_ans("ans123",   123,    1'b1, 0, -1);
        run_ans("ans0",     0,      1'b1, 0, -1);
        run_ans("ansmin",   -32768, 1'b1, 0, -1);
        run_ans("ansmax",   32767,  1'b1, 0, -1);
        run_ans("ans10000", 10000,  1'b1, 0, -1);
        run_ans("ans_m7",   -7,     1'b1, 5, -1);
        run_ans("ans42",    42,     1'b1, 0, 1);
        run_ans("nocrlf5",  5,      1'b0, 0, -1);
        run_ans("nocrlf0",  0,      1'b0, 0, -1);
        run_ans("nocrlf_m1", -1,    1'b0, 0, -1);

        // reset while the '3' of 12345 is stalled on the line
        sel1 = 1'b1;
        @(negedge clk);
        ans = 16'd12345;
        ans_ready1 = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        ans_ready1 = 1'b0;
        k = 0;
        while (!(o_valid && o_data == 8'h33) && k < 100) begin
            @(negedge clk);
            k++;
        end
        tx_ready = 1'b0;
        check("rst_mid reached_3", {31'd0, (k < 100)}, 32'd1);
        #1 rst = 1'b1;
        #1 check("rst_mid async", {20'd0, d1, v1, b1, dr1, 1'b0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("rst_mid quiet%0d", i), {30'd0, v1, b1}, 32'd0);
        end

        // first edge after release must accept a strobe
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ans = 16'd8;
        ans_ready1 = 1'b1;
        @(negedge clk);
        ans_ready1 = 1'b0;
        check("post_rst accept", {31'd0, b1}, 32'd1);
        k = 0;
        while (b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("post_rst drain", {31'd0, (k < 100)}, 32'd1);

        for (int i = 0; i < 24; i++) begin
            rv = int'($urandom_range(0, 65535)) - 32768;
            run_ans($sformatf("rand%0d", i), rv, ($urandom_range(0, 1) == 1), 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
